// File: rtl/detect_pkg.sv
// Shared types and defaults for the detect_tx_scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package detect_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    GAP
  } sched_state_e;

  localparam int NUM_REQ_DEF     = 4;
  localparam int DATA_W_DEF      = 8;
  localparam int GAP_CYC_DEF     = 16;
  localparam int TIMEOUT_CYC_DEF = 2_500_000;

endpackage

// File: rtl/detect_tx_scheduler_rr_arbiter.sv
// Round-robin priority encoder: first set req bit at or after ptr, with wrap.
// Latency: combinational.
// Backpressure: none; grant_valid is simply |req.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_valid
);

  int j;

  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    j           = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!grant_valid && req[j[PTR_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = j[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/detect_tx_scheduler.sv
// Shares one UART between NUM_REQ detectors; optional TX_TIMEOUT_EN adds a tx_done watchdog.
// Latency: strobe at t with scheduler idle -> tx_start at t+2; frames spaced >= GAP_CYC+2 after tx_done.
// Backpressure: strobes are latched as pending (newest data wins, overrun flagged); tx_busy holds IDLE.
module detect_tx_scheduler
  import detect_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int GAP_CYC     = GAP_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_start,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  output logic [NUM_REQ-1:0]        pend,
  output logic [NUM_REQ-1:0]        overrun,
  output logic                      timeout_err
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  sched_state_e        state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    grant_idx;
  logic                grant_valid;
  logic                grant;
  logic [NUM_REQ-1:0]  grant_mask;
  logic [GAP_W-1:0]    gap_cnt;
  logic [DATA_W-1:0]   data_q [NUM_REQ];
  logic                tmo_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req         (pend),
    .ptr         (rr_ptr),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid && !tx_busy) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE:     state_d = WAIT_DONE;
      WAIT_DONE: if (tx_done || tmo_hit) state_d = GAP;
      GAP:       if (gap_cnt == GAP_LAST) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign tx_start   = (state_q == ISSUE);
  assign grant_mask = grant ? (NUM_REQ'(1) << grant_idx) : '0;

  // A strobe on the requester being granted is not an overrun: its old data leaves in tx_data this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_ptr  <= '0;
      gap_cnt <= '0;
      tx_data <= '0;
      pend    <= '0;
      overrun <= '0;
    end else begin
      state_q <= state_d;
      pend    <= (pend & ~grant_mask) | req_start;
      overrun <= overrun | (req_start & pend & ~grant_mask);
      if (grant) begin
        tx_data <= data_q[grant_idx];
        rr_ptr  <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
      end
      if (state_q == GAP) gap_cnt <= gap_cnt + 1'b1;
      else                gap_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (req_start[i]) data_q[i] <= req_data[i*DATA_W +: DATA_W];
    end
  end

`ifdef TX_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt;

  // A timed-out frame is dropped: the FSM moves to GAP exactly as if tx_done had arrived.
  assign tmo_hit = (state_q == WAIT_DONE) && !tx_done && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_q == WAIT_DONE) tmo_cnt <= tmo_cnt + 1'b1;
      else                      tmo_cnt <= '0;
      if (tmo_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_detect_tx_scheduler.sv
// Randomized + directed bench for detect_tx_scheduler with a rule-level reference model and scoreboard.
module tb_detect_tx_scheduler;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int GAP = 16;
  localparam int TMO = 50;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_start = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic              tx_busy = 1'b0;
  logic              tx_done = 1'b0;
  logic              tx_start;
  logic [DW-1:0]     tx_data;
  logic [N-1:0]      pend;
  logic [N-1:0]      overrun;
  logic              timeout_err;

  detect_tx_scheduler #(.NUM_REQ(N), .DATA_W(DW), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_start(req_start), .req_data(req_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data),
    .pend(pend), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model (spec rules, cycle numbers) ----------------
  typedef struct { int cyc; logic [DW-1:0] dat; } exp_t;
  exp_t           exp_q[$];
  logic [DW-1:0]  started[$];
  logic [N-1:0]   m_pend = '0;
  logic [N-1:0]   m_ovr = '0;
  logic           m_tmo = 1'b0;
  logic [DW-1:0]  m_txdata = '0;
  logic [DW-1:0]  m_data [N];
  int             m_ptr = 0;
  bit             m_inflight = 0;
  int             m_start = 0;
  int             m_next = 0;

  always @(posedge clk or negedge rst_n) begin
    int w;
    logic [N-1:0] pre;
    bit done_ok;
    if (!rst_n) begin
      m_pend = '0; m_ovr = '0; m_tmo = 1'b0; m_txdata = '0; m_ptr = 0;
      m_inflight = 0; m_start = 0; m_next = 0;
      for (int i = 0; i < N; i++) m_data[i] = '0;
      exp_q.delete();
    end else begin
      pre = m_pend;
      w = -1;
      if (!m_inflight && cyc >= m_next && !tx_busy && (m_pend != '0)) begin
        for (int k = 0; k < N; k++)
          if (w < 0 && m_pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        m_txdata = m_data[w];
        exp_q.push_back('{cyc: cyc + 1, dat: m_data[w]});
        m_pend[w] = 1'b0;
        m_ptr = (w + 1) % N;
        m_inflight = 1;
        m_start = cyc + 1;
      end
      done_ok = m_inflight && (cyc > m_start) && tx_done;
      if (done_ok) begin
        m_inflight = 0;
        m_next = cyc + GAP + 1;
      end
`ifdef TX_TIMEOUT_EN
      else if (m_inflight && (cyc - m_start) == TMO) begin
        m_tmo = 1'b1;
        m_inflight = 0;
        m_next = cyc + GAP + 1;
      end
`endif
      for (int i = 0; i < N; i++) begin
        if (req_start[i]) begin
          if (pre[i] && i != w) m_ovr[i] = 1'b1;
          m_pend[i] = 1'b1;
          m_data[i] = req_data[i*DW +: DW];
        end
      end
      cyc = cyc + 1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    if (tx_start) begin
      started.push_back(tx_data);
      if (exp_q.size() == 0) chk("unexpected_tx_start", tx_start, 0);
      else begin
        e = exp_q.pop_front();
        chk("tx_start_cycle", cyc, e.cyc);
        chk("tx_start_data", tx_data, e.dat);
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      chk("missing_tx_start", tx_start, 1);
      void'(exp_q.pop_front());
    end
    chk("pend", pend, m_pend);
    chk("overrun", overrun, m_ovr);
    chk("timeout_err", timeout_err, m_tmo);
    chk("tx_data_hold", tx_data, m_txdata);
  end

  // ---------------- UART model ----------------
  int done_dly = 10;
  bit uart_mute = 0;
  bit spur_en = 0;
  bit busy_en = 0;

  initial begin
    int cnt;
    bit fbusy;
    cnt = 0;
    fbusy = 0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (!rst_n) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0 && !uart_mute) tx_done = 1'b1;
        end
        if (tx_start) cnt = done_dly;
        if (spur_en && $urandom_range(0, 99) < 2) tx_done = 1'b1;
      end
      if (!busy_en) fbusy = 0;
      else if ($urandom_range(0, 99) < 3) fbusy = ~fbusy;
      tx_busy = (cnt > 0) || fbusy;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    req_start = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    started.delete();
  endtask

  task automatic strobe(input logic [N-1:0] m, input logic [N*DW-1:0] d);
    @(negedge clk);
    req_start = m;
    req_data  = d;
    @(negedge clk);
    req_start = '0;
  endtask

  task automatic wait_start(input string name);
    bit ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx_start) begin ok = 1; break; end
    end
    if (!ok) begin n_chk++; $display("FAIL %s: no tx_start within 500 cycles, required one", name); end
  endtask

  task automatic wait_quiet();
    bit ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!m_inflight && m_pend == '0 && exp_q.size() == 0 && cyc > m_next) begin ok = 1; break; end
    end
    if (!ok) begin n_chk++; $display("FAIL quiet_timeout: still busy after 5000 cycles, required idle"); end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    int nst;
    int r;
    int n;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_pend", pend, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout_err, 0);
    #2 rst_n = 1'b1;

    // single request, tx_start two cycles after the strobe
    done_dly = 100;
    strobe(4'b0100, {8'h00, 8'h01, 8'h00, 8'h00});
    @(negedge clk);
    chk("t1_latency", tx_start, 1);
    chk("t1_data", tx_data, 8'h01);
    wait_quiet();
    chk("t1_pend_after", pend, 0);

    // simultaneous requests issue in index order
    apply_reset();
    done_dly = 20;
    strobe(4'b1011, {8'hA3, 8'h00, 8'hA1, 8'hA0});
    wait_quiet();
    chk("t2_nframes", started.size(), 3);
    chk("t2_order0", started[0], 8'hA0);
    chk("t2_order1", started[1], 8'hA1);
    chk("t2_order2", started[2], 8'hA3);

    // fairness: both requesters keep re-strobing after their grant
    apply_reset();
    done_dly = 5;
    strobe(4'b0011, {16'h0, 8'hF1, 8'hF0});
    for (int k = 0; k < 4; k++) begin
      wait_start("t3_start");
      r = (tx_data == 8'hF0) ? 0 : 1;
      if (k < 3) begin
        req_start = (r == 0) ? 4'b0001 : 4'b0010;
        req_data  = {16'h0, 8'hF1, 8'hF0};
        @(negedge clk);
        req_start = '0;
      end
    end
    wait_quiet();
    chk("t3_fair0", started[0], 8'hF0);
    chk("t3_fair1", started[1], 8'hF1);
    chk("t3_fair2", started[2], 8'hF0);
    chk("t3_fair3", started[3], 8'hF1);

    // overrun: newest data wins, flag sticks
    apply_reset();
    done_dly = 60;
    strobe(4'b1000, {8'h33, 24'h0});
    repeat (10) @(negedge clk);
    strobe(4'b0010, {16'h0, 8'h11, 8'h00});
    repeat (5) @(negedge clk);
    strobe(4'b0010, {16'h0, 8'h22, 8'h00});
    wait_quiet();
    chk("t4_nframes", started.size(), 2);
    chk("t4_frame1", started[1], 8'h22);
    chk("t4_overrun", overrun, 4'b0010);
    repeat (30) @(negedge clk);
    chk("t4_overrun_sticky", overrun, 4'b0010);

    // grant collision keeps the event, then reset mid-frame
    apply_reset();
    done_dly = 30;
    @(negedge clk); req_start = 4'b0001; req_data = {24'h0, 8'h5A};
    @(negedge clk); req_start = 4'b0001; req_data = {24'h0, 8'h5B};
    @(negedge clk); req_start = '0;
    chk("t5_start1", tx_start, 1);
    chk("t5_data1", tx_data, 8'h5A);
    chk("t5_pend_kept", pend[0], 1);
    wait_start("t5_start2");
    chk("t5_data2", tx_data, 8'h5B);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_start", tx_start, 0);
    chk("t5_rst_data", tx_data, 0);
    chk("t5_rst_pend", pend, 0);
    chk("t5_rst_ovr", overrun, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    nst = started.size();
    repeat (200) @(negedge clk);
    chk("t5_no_start_after_rst", started.size(), nst);

`ifdef TX_TIMEOUT_EN
    // withheld tx_done: timeout at WAIT_DONE cycle TMO, next request still served
    apply_reset();
    uart_mute = 1;
    done_dly = 10;
    strobe(4'b1100, {8'hC3, 8'hC2, 16'h0});
    wait_start("tmo_start");
    chk("tmo_first", tx_data, 8'hC2);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (timeout_err) break;
    end
    chk("tmo_latency", n, TMO + 1);
    uart_mute = 0;
    wait_quiet();
    chk("tmo_next_issued", started[started.size()-1], 8'hC3);
    chk("tmo_sticky", timeout_err, 1);
`endif

    // randomized traffic: sparse strobes, foreign busy, spurious tx_done
    apply_reset();
    spur_en = 1;
    busy_en = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      for (int b = 0; b < N; b++) req_start[b] = ($urandom_range(0, 99) < 4);
      req_data = $urandom;
      done_dly = $urandom_range(1, 25);
      if (i == 2000) apply_reset();
    end
    @(negedge clk);
    req_start = '0;
    spur_en = 0;
    busy_en = 0;
    wait_quiet();
    chk("rand_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
